// File: rtl/input_debounce.sv
// Input conditioning for board buttons/switches: 2-FF synchroniser, tick-based
// debounce filter, registered rise/fall pulses and a long-press event per channel.
module input_debounce #(
    parameter int unsigned CW       = 4,
    parameter int unsigned PRESCALE = 65536,
    parameter int unsigned DEBOUNCE = 10,
    parameter int unsigned LONG     = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] in_raw,
    output logic [CW-1:0] in_stable,
    output logic [CW-1:0] rise,
    output logic [CW-1:0] fall,
    output logic [CW-1:0] long_press,
    output logic          tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
    localparam int unsigned HW = (LONG > 0) ? $clog2(LONG + 1) : 1;

    localparam logic [PW-1:0] PS_WRAP = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PS_PRE  = PW'(PRESCALE - 2);
    localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE - 1);
    localparam logic [HW-1:0] HC_MAX  = HW'(LONG);

    logic [CW-1:0] sync_q1;
    logic [CW-1:0] sync_s;
    logic [PW-1:0] ps_cnt;
    logic [DW-1:0] dc     [CW];
    logic [DW-1:0] dc_nxt [CW];
    logic [HW-1:0] hc     [CW];
    logic [HW-1:0] hc_nxt [CW];
    logic [CW-1:0] stable_nxt;
    logic [CW-1:0] stable_d;
    logic [CW-1:0] hc_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_s  <= '0;
        end else begin
            sync_q1 <= in_raw;
            sync_s  <= sync_q1;
        end
    end

    // tick is registered one count early so it is high while ps_cnt == PRESCALE-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt <= '0;
            tick   <= 1'b0;
        end else begin
            if (ps_cnt == PS_WRAP) ps_cnt <= '0;
            else                   ps_cnt <= ps_cnt + PW'(1);
            tick <= (ps_cnt == PS_PRE);
        end
    end

    always_comb begin
        stable_nxt = in_stable;
        for (int unsigned i = 0; i < CW; i++) begin
            dc_nxt[i] = dc[i];
            if (sync_s[i] == in_stable[i]) begin
                dc_nxt[i] = '0;
            end else if (tick && (dc[i] == DC_LAST)) begin
                stable_nxt[i] = sync_s[i];
                dc_nxt[i]     = '0;
            end else if (tick) begin
                dc_nxt[i] = dc[i] + DW'(1);
            end
        end
    end

    // a release coinciding with the final hold tick clears hc before it can reach LONG
    always_comb begin
        for (int unsigned i = 0; i < CW; i++) begin
            hc_nxt[i] = hc[i];
            if (!in_stable[i] || !stable_nxt[i]) begin
                hc_nxt[i] = '0;
            end else if (tick && (hc[i] != HC_MAX)) begin
                hc_nxt[i] = hc[i] + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CW; i++) begin
                dc[i] <= '0;
                hc[i] <= '0;
            end
            in_stable  <= '0;
            stable_d   <= '0;
            rise       <= '0;
            fall       <= '0;
            hc_full    <= '0;
            long_press <= '0;
        end else begin
            for (int unsigned i = 0; i < CW; i++) begin
                dc[i]         <= dc_nxt[i];
                hc[i]         <= hc_nxt[i];
                hc_full[i]    <= (hc[i] == HC_MAX);
                long_press[i] <= (hc[i] == HC_MAX) && !hc_full[i];
            end
            in_stable <= stable_nxt;
            stable_d  <= in_stable;
            rise      <= in_stable & ~stable_d;
            fall      <= ~in_stable & stable_d;
        end
    end

endmodule

// File: tb/tb_input_debounce.sv
// Scoreboard bench for input_debounce: a cycle-count reference model queues the
// expected outputs per clock, a monitor pops and compares them on the falling edge.
module tb_input_debounce;

    localparam int unsigned CW = 4;
    localparam int unsigned P  = 4;
    localparam int unsigned D  = 3;
    localparam int unsigned L  = 5;

    typedef logic [4*CW:0] exp_t;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic [CW-1:0] in_raw = '0;
    logic [CW-1:0] in_stable;
    logic [CW-1:0] rise;
    logic [CW-1:0] fall;
    logic [CW-1:0] long_press;
    logic          tick;

    input_debounce #(
        .CW       (CW),
        .PRESCALE (P),
        .DEBOUNCE (D),
        .LONG     (L)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_raw     (in_raw),
        .in_stable  (in_stable),
        .rise       (rise),
        .fall       (fall),
        .long_press (long_press),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    int unsigned   m_cyc;
    logic [CW-1:0] m_s1, m_s2, m_st, m_st_prev;
    int            m_dc[CW];
    int            m_hc[CW];
    int            m_hc_prev[CW];

    task automatic model_reset();
        m_cyc     = 0;
        m_s1      = '0;
        m_s2      = '0;
        m_st      = '0;
        m_st_prev = '0;
        for (int i = 0; i < CW; i++) begin
            m_dc[i]      = 0;
            m_hc[i]      = 0;
            m_hc_prev[i] = 0;
        end
        exp_q.delete();
    endtask

    // Advance the reference by one clock edge and queue what the outputs must show after it.
    task automatic model_step();
        logic [CW-1:0] st_n, r_n, f_n, lp_n;
        bit            tk;
        exp_t          e;
        tk   = (m_cyc % P) == P - 1;
        st_n = m_st;
        for (int i = 0; i < CW; i++) begin
            if (m_s2[i] == m_st[i]) begin
                m_dc[i] = 0;
            end else if (tk) begin
                if (m_dc[i] == D - 1) begin
                    st_n[i] = m_s2[i];
                    m_dc[i] = 0;
                end else begin
                    m_dc[i]++;
                end
            end
            lp_n[i]      = (m_hc[i] == L) && (m_hc_prev[i] != L);
            m_hc_prev[i] = m_hc[i];
            if (!m_st[i] || !st_n[i]) m_hc[i] = 0;
            else if (tk && m_hc[i] < L) m_hc[i]++;
        end
        r_n       = m_st & ~m_st_prev;
        f_n       = ~m_st & m_st_prev;
        m_st_prev = m_st;
        m_st      = st_n;
        m_s2      = m_s1;
        m_s1      = in_raw;
        m_cyc++;
        e = {m_st, r_n, f_n, lp_n, ((m_cyc % P) == P - 1)};
        exp_q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    task automatic check(input string name, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got st=%b r=%b f=%b lp=%b t=%b want st=%b r=%b f=%b lp=%b t=%b",
                     name, $time,
                     got[4*CW -: CW], got[3*CW -: CW], got[2*CW -: CW], got[CW -: CW], got[0],
                     want[4*CW -: CW], want[3*CW -: CW], want[2*CW -: CW], want[CW -: CW], want[0]);
        end
    endtask

    initial begin
        exp_t got;
        exp_t want;
        forever begin
            @(negedge clk);
            got = {in_stable, rise, fall, long_press, tick};
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check("outputs", got, want);
            end else if (!rst_n) begin
                want = '0;
                check("reset", got, want);
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset(input int n);
        #2 rst_n = 1'b0;
        hold(n);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int hold_c[CW];
        #1 rst_n = 1'b0;
        hold(50);
        #2 rst_n = 1'b1;
        hold(20);

        in_raw[0] = 1'b1; hold(25);

        in_raw[1] = 1'b1; hold(6);
        in_raw[1] = 1'b0; hold(15);
        in_raw[1] = 1'b1; hold(20);

        in_raw[2] = 1'b1; hold(75);
        in_raw[2] = 1'b0; hold(25);
        in_raw[2] = 1'b1; hold(45);
        in_raw[2] = 1'b0; hold(20);

        // reset while ch2 is mid long-press and ch3 is mid-debounce
        in_raw = '0;      hold(25);
        in_raw[2] = 1'b1; hold(30);
        in_raw[3] = 1'b1; hold(11);
        pulse_reset(3);
        hold(40);

        in_raw = '0; hold(30);
        in_raw = '1; hold(30);
        in_raw = '0; hold(30);

        for (int i = 0; i < CW; i++) hold_c[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < CW; i++) begin
                if (hold_c[i] == 0) begin
                    in_raw[i] = ~in_raw[i];
                    hold_c[i] = $urandom_range(1, 45);
                end else begin
                    hold_c[i]--;
                end
            end
            if ((cyc % 750) == 400) begin
                pulse_reset(1 + $urandom_range(0, 2));
            end else begin
                hold(1);
            end
        end

        hold(5);
        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending entries want at most 1", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
